// File: rtl/motor_pkg.sv
// Shared types and constants for the motor sequencer slice.
package motor_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_RAMP_DOWN = 2'd1,
    ST_DEAD      = 2'd2,
    ST_FAULT     = 2'd3
  } state_e;

  localparam int DUTY_W_DEF = 8;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BWD = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/trip_monitor.sv
// Overcurrent trip monitor: OVER1 rising-edge detect, trip window timer
// and a saturating trip counter. Flags when the count reaches the limit.
module trip_monitor
  import motor_pkg::*;
#(
  parameter int TRIP_LIMIT    = 3,
  parameter int WINDOW_CYCLES = 5000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_over,
  input  logic i_en,
  input  logic i_clr,
  output logic o_trip_limit_hit
);

  localparam int CNT_W = cnt_w(TRIP_LIMIT + 1);
  localparam int WIN_W = cnt_w(WINDOW_CYCLES);

  logic             r_over_q;
  logic [CNT_W-1:0] r_cnt;
  logic [WIN_W-1:0] r_win;
  logic             r_win_act;

  logic w_trip;
  logic w_win_end;

  // Rising edge of OVER1; trips are masked while the sequencer is faulted.
  assign w_trip    = i_en && i_over && !r_over_q;
  assign w_win_end = r_win_act && (r_win == WIN_W'(WINDOW_CYCLES - 1));

  // Registered copy of OVER1 for edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_over_q <= 1'b0;
    else     r_over_q <= i_over;
  end

  // Window timer and saturating trip count; a trip on the window's last
  // cycle opens a fresh window with count 1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt     <= '0;
      r_win     <= '0;
      r_win_act <= 1'b0;
    end else if (i_clr) begin
      r_cnt     <= '0;
      r_win     <= '0;
      r_win_act <= 1'b0;
    end else if (w_win_end) begin
      r_win     <= '0;
      r_win_act <= w_trip;
      r_cnt     <= w_trip ? CNT_W'(1) : '0;
    end else begin
      if (w_trip && r_cnt == '0) begin
        r_win_act <= 1'b1;
        r_win     <= '0;
      end else if (r_win_act) begin
        r_win <= r_win + WIN_W'(1);
      end
      if (w_trip && r_cnt != CNT_W'(TRIP_LIMIT))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_trip_limit_hit = (r_cnt == CNT_W'(TRIP_LIMIT));

endmodule

// File: rtl/motor_sequencer.sv
// Motor sequencer: soft-start/stop duty ramp, dead time on reversal and
// latched overcurrent fault ahead of the PWM / H-bridge path.
module motor_sequencer
  import motor_pkg::*;
#(
  parameter int DUTY_W        = DUTY_W_DEF,
  parameter int RAMP_DIV      = 1000,
  parameter int DEAD_CYCLES   = 50000,
  parameter int TRIP_LIMIT    = 3,
  parameter int WINDOW_CYCLES = 5000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DUTY_W-1:0] DUTY_REQ,
  input  logic              DIR_REQ,
  input  logic              OVER1,
  input  logic              FAULT_CLR,
  output logic [DUTY_W-1:0] DUTY_OUT,
  output logic              DIR_OUT,
  output logic              FAULT,
  output logic              BUSY
);

  localparam int PRE_W  = cnt_w(RAMP_DIV);
  localparam int DEAD_W = cnt_w(DEAD_CYCLES);

  state_e            r_state;
  logic [PRE_W-1:0]  r_pre;
  logic [DEAD_W-1:0] r_dead;
  logic [DUTY_W-1:0] r_duty;
  logic              r_dir;
  logic              r_fault;
  logic              r_busy;

  state_e            w_state_nxt;
  logic [DUTY_W-1:0] w_duty_nxt;
  logic              w_dir_nxt;
  logic              w_tick;
  logic              w_dead_end;
  logic              w_hit;
  logic              w_clr;
  logic              w_trip_en;

  assign w_tick     = (r_pre == PRE_W'(RAMP_DIV - 1));
  assign w_dead_end = (r_state == ST_DEAD) && (r_dead == DEAD_W'(DEAD_CYCLES - 1));
  assign w_clr      = (r_state == ST_FAULT) && (w_state_nxt == ST_RUN);
  assign w_trip_en  = (r_state != ST_FAULT);

  trip_monitor #(
    .TRIP_LIMIT    (TRIP_LIMIT),
    .WINDOW_CYCLES (WINDOW_CYCLES)
  ) u_trip (
    .CLK              (CLK),
    .RST              (RST),
    .i_over           (OVER1),
    .i_en             (w_trip_en),
    .i_clr            (w_clr),
    .o_trip_limit_hit (w_hit)
  );

  // Free-running ramp prescaler, independent of state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_pre <= '0;
    else     r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
  end

  // Dead-time counter: zero outside DEAD so it is loaded on entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                r_dead <= '0;
    else if (r_state == ST_DEAD && !w_dead_end) r_dead <= r_dead + DEAD_W'(1);
    else                                    r_dead <= '0;
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: fault entry beats direction change beats ramp.
  always_comb begin
    w_state_nxt = r_state;
    if (w_hit && r_state != ST_FAULT) begin
      w_state_nxt = ST_FAULT;
    end else begin
      case (r_state)
        ST_RUN:       if (DIR_REQ != r_dir) w_state_nxt = ST_RAMP_DOWN;
        ST_RAMP_DOWN: if (DIR_REQ == r_dir) w_state_nxt = ST_RUN;
                      else if (r_duty == '0) w_state_nxt = ST_DEAD;
        ST_DEAD:      if (w_dead_end) w_state_nxt = ST_RUN;
        ST_FAULT:     if (FAULT_CLR && DUTY_REQ == '0) w_state_nxt = ST_RUN;
        default:      w_state_nxt = ST_RUN;
      endcase
    end
  end

  // Next output values; duty only moves on ticks and never overshoots.
  always_comb begin
    w_duty_nxt = r_duty;
    w_dir_nxt  = r_dir;
    if (w_state_nxt == ST_FAULT) begin
      w_duty_nxt = '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (DIR_REQ == r_dir && w_tick) begin
            if (r_duty < DUTY_REQ)      w_duty_nxt = r_duty + DUTY_W'(1);
            else if (r_duty > DUTY_REQ) w_duty_nxt = r_duty - DUTY_W'(1);
          end
        end
        ST_RAMP_DOWN: begin
          if (DIR_REQ != r_dir && w_tick && r_duty != '0)
            w_duty_nxt = r_duty - DUTY_W'(1);
        end
        ST_DEAD: begin
          w_duty_nxt = '0;
          if (w_dead_end) w_dir_nxt = DIR_REQ;
        end
        default: w_duty_nxt = '0;
      endcase
    end
  end

  // Registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_duty  <= '0;
      r_dir   <= DIR_FWD;
      r_fault <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_duty  <= w_duty_nxt;
      r_dir   <= w_dir_nxt;
      r_fault <= (w_state_nxt == ST_FAULT);
      r_busy  <= (w_state_nxt == ST_RAMP_DOWN) || (w_state_nxt == ST_DEAD);
    end
  end

  assign DUTY_OUT = r_duty;
  assign DIR_OUT  = r_dir;
  assign FAULT    = r_fault;
  assign BUSY     = r_busy;

endmodule

// File: tb/tb_motor_sequencer.sv
// Directed bench for motor_sequencer with short ramp, dead and window times.
module tb_motor_sequencer;
  import motor_pkg::*;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] DUTY_REQ = '0;
  logic          DIR_REQ = DIR_FWD;
  logic          OVER1 = 1'b0;
  logic          FAULT_CLR = 1'b0;
  logic [DW-1:0] DUTY_OUT;
  logic          DIR_OUT;
  logic          FAULT;
  logic          BUSY;

  int n_chk = 0;
  int n_err = 0;

  motor_sequencer #(
    .DUTY_W(DW), .RAMP_DIV(4), .DEAD_CYCLES(10),
    .TRIP_LIMIT(3), .WINDOW_CYCLES(100)
  ) dut (
    .CLK(CLK), .RST(RST), .DUTY_REQ(DUTY_REQ), .DIR_REQ(DIR_REQ),
    .OVER1(OVER1), .FAULT_CLR(FAULT_CLR), .DUTY_OUT(DUTY_OUT),
    .DIR_OUT(DIR_OUT), .FAULT(FAULT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse();
    OVER1 = 1'b1; step(1);
    OVER1 = 1'b0; step(1);
  endtask

  initial begin
    step(2);
    chk("rst_duty", 32'(DUTY_OUT), 0);
    chk("rst_dir", 32'(DIR_OUT), 0);
    chk("rst_fault", 32'(FAULT), 0);
    chk("rst_busy", 32'(BUSY), 0);

    // Soft start: ticks on edges 4,8,...,20 after release.
    RST = 1'b0; DUTY_REQ = 8'd5; DIR_REQ = DIR_FWD;
    for (int k = 1; k <= 5; k++) begin
      step(3); chk($sformatf("ss_pre%0d", k), 32'(DUTY_OUT), 32'(k - 1));
      step(1); chk($sformatf("ss_tick%0d", k), 32'(DUTY_OUT), 32'(k));
    end
    step(8);
    chk("ss_hold", 32'(DUTY_OUT), 5);
    chk("ss_dir", 32'(DIR_OUT), 0);
    chk("ss_busy", 32'(BUSY), 0);

    // Reversal (edge 28, prescaler phase 0).
    DIR_REQ = DIR_BWD;
    step(1);  chk("rv_busy", 32'(BUSY), 1); chk("rv_duty5", 32'(DUTY_OUT), 5);
    step(3);  chk("rv_duty4", 32'(DUTY_OUT), 4);
    step(16); chk("rv_duty0", 32'(DUTY_OUT), 0); chk("rv_dir_old", 32'(DIR_OUT), 0);
    step(1);  chk("rv_dead_busy", 32'(BUSY), 1);
    step(9);  chk("rv_dead_dir", 32'(DIR_OUT), 0); chk("rv_dead_busy2", 32'(BUSY), 1);
              chk("rv_dead_duty", 32'(DUTY_OUT), 0);
    step(1);  chk("rv_dir_new", 32'(DIR_OUT), 1); chk("rv_busy_off", 32'(BUSY), 0);
    step(1);  chk("rv_up1", 32'(DUTY_OUT), 1);
    step(16); chk("rv_up5", 32'(DUTY_OUT), 5);

    // Aborted reversal: request forward, return at duty 3.
    DIR_REQ = DIR_FWD;
    step(8);  chk("ab_duty3", 32'(DUTY_OUT), 3); chk("ab_busy", 32'(BUSY), 1);
    DIR_REQ = DIR_BWD;
    step(1);  chk("ab_run_busy", 32'(BUSY), 0); chk("ab_hold3", 32'(DUTY_OUT), 3);
    step(7);  chk("ab_duty5", 32'(DUTY_OUT), 5); chk("ab_dir", 32'(DIR_OUT), 1);

    // Three trips inside the window latch FAULT and zero the duty at once.
    pulse(); pulse();
    chk("tw_no_fault", 32'(FAULT), 0);
    OVER1 = 1'b1; step(1); OVER1 = 1'b0;
    chk("tw_pre_fault", 32'(FAULT), 0);
    step(1);
    chk("tw_fault", 32'(FAULT), 1);
    chk("tw_duty0", 32'(DUTY_OUT), 0);
    chk("tw_dir_hold", 32'(DIR_OUT), 1);

    // Clear needs DUTY_REQ == 0 in the same cycle.
    FAULT_CLR = 1'b1;
    step(3);  chk("fc_blocked", 32'(FAULT), 1); chk("fc_blk_duty", 32'(DUTY_OUT), 0);
    DUTY_REQ = 8'd0;
    step(1);  chk("fc_clear", 32'(FAULT), 0); chk("fc_duty", 32'(DUTY_OUT), 0);
              chk("fc_busy", 32'(BUSY), 0);
    FAULT_CLR = 1'b0;

    // Two trips, window expires, one late trip starts a new window (count 1):
    // two more trips then reach the limit.
    pulse(); pulse();
    step(120);
    pulse();
    step(2);  chk("we_no_fault", 32'(FAULT), 0);
    pulse();  chk("we_no_fault2", 32'(FAULT), 0);
    pulse();  chk("we_fault", 32'(FAULT), 1);
    FAULT_CLR = 1'b1;
    step(1);  chk("we_clear", 32'(FAULT), 0);
    FAULT_CLR = 1'b0;

    // Async reset while serving dead time.
    DIR_REQ = DIR_FWD;
    step(6);
    chk("ar_busy", 32'(BUSY), 1); chk("ar_dir", 32'(DIR_OUT), 1);
    #2 RST = 1'b1;
    #1;
    chk("ar_rst_duty", 32'(DUTY_OUT), 0);
    chk("ar_rst_dir", 32'(DIR_OUT), 0);
    chk("ar_rst_busy", 32'(BUSY), 0);
    chk("ar_rst_fault", 32'(FAULT), 0);
    #10 RST = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/motor_sequencer.md
Name: motor_sequencer

Overview:
- Supervisory controller ahead of the H-bridge motor control path: turns a requested duty and direction into a ramped duty command and a safe direction output.
- Soft-start/soft-stop ramp, dead time on every direction reversal, and an overcurrent trip counter that latches a fault after repeated trips within a time window.
- DUTY_OUT feeds the PWM generator.
- DIR_OUT drives the motor control direction select (SW7 position).
- OVER1 is the same >1 A comparator flag used by the cycle-by-cycle current protection.

Parameters:
- DUTY_W, 8, duty command width.
- RAMP_DIV, 1000, CLK cycles per ramp tick (one duty LSB step per tick); must be >=2.
- DEAD_CYCLES, 50000, CLK cycles with duty held at 0 before DIR_OUT may change; must be >=1.
- TRIP_LIMIT, 3, overcurrent trips within one window that latch FAULT; must be >=1.
- WINDOW_CYCLES, 5000000, trip-counting window length in CLK cycles.

Ports:
- CLK  input  1  system clock
- RST  input  1  asynchronous, active-high reset
- DUTY_REQ  input  DUTY_W  requested duty magnitude (0 = stop)
- DIR_REQ  input  1  requested direction, 0 = forward, 1 = backward
- OVER1  input  1  overcurrent flag, synchronous to CLK
- FAULT_CLR  input  1  level; clears a latched fault
- DUTY_OUT  output  DUTY_W  ramped duty command to the PWM generator
- DIR_OUT  output  1  direction to motor control
- FAULT  output  1  latched trip fault
- BUSY  output  1  high while in RAMP_DOWN or DEAD (reversal in progress)

Behaviour:
- Reset (async, RST=1): state RUN, DUTY_OUT=0, DIR_OUT=0, FAULT=0, BUSY=0, all counters 0. All outputs are registered.
- Ramp tick:
  - Free-running prescaler 0..RAMP_DIV-1; tick is asserted for one cycle when the count equals RAMP_DIV-1.
  - The prescaler runs in every state and restarts at 0 on reset.
- State RUN:
  - DIR_REQ == DIR_OUT: on each tick DUTY_OUT steps by 1 toward DUTY_REQ (+1 if lower, -1 if higher, hold if equal). No overshoot; no step between ticks.
  - DIR_REQ != DIR_OUT: go to RAMP_DOWN on the next cycle.
- State RAMP_DOWN:
  - DUTY_OUT decrements by 1 per tick.
  - If DIR_REQ returns to DIR_OUT, go back to RUN (ramp resumes from the current duty).
  - When DUTY_OUT == 0, load the dead counter and go to DEAD.
  - If DUTY_OUT is already 0 on entry, go to DEAD on the next cycle.
- State DEAD:
  - DUTY_OUT held at 0; counts DEAD_CYCLES cycles.
  - On expiry: DIR_OUT <= DIR_REQ sampled that cycle, go to RUN.
  - If DIR_REQ equals the old DIR_OUT at expiry, DIR_OUT is unchanged. The dead time is always served in full.
- State FAULT:
  - DUTY_OUT forced to 0 on the cycle FAULT is set. No ramp down.
  - DIR_OUT holds; trips are ignored.
  - Exit to RUN, with trip counter and window cleared and FAULT=0, only when FAULT_CLR==1 and DUTY_REQ==0 in the same cycle.
  - FAULT_CLR is ignored in all other states.
- Trip monitor:
  - Registered copy of OVER1; a trip is a 0->1 rising edge of OVER1.
  - The first trip with count 0 starts the window timer. Each trip increments the count, saturating at TRIP_LIMIT.
  - When the window timer reaches WINDOW_CYCLES-1, count and timer clear. A trip on that same cycle counts as the first trip of a new window (count=1).
  - When count reaches TRIP_LIMIT, enter FAULT on the next cycle from any state.
- Priority: fault entry > direction change > duty ramp.
- Simultaneous cases:
  - Trip reaching the limit in the same cycle as DEAD expiry: FAULT wins; DIR_OUT keeps its old value.
- Width rules:
  - Duty arithmetic is unsigned DUTY_W; DUTY_OUT never wraps below 0 or above DUTY_REQ.
  - Counters are sized by $clog2 of their parameters.
- RST asserted mid-reversal or mid-fault: immediate return to reset values.

Decomposition:
- Shared package motor_pkg:
  - State encoding typedef (RUN, RAMP_DOWN, DEAD, FAULT).
  - DUTY_W default.
  - Direction constants DIR_FWD=0, DIR_BWD=1.
- One sub-module, trip_monitor:
  - Contains the OVER1 edge detect, window timer and saturating trip counter.
  - Outputs: trip_limit_hit.
  - Inputs: clr (pulsed on fault exit), CLK, RST.
- The ramp prescaler and state machine stay in motor_sequencer.

Test Plan:
Bench parameters: RAMP_DIV=4, DEAD_CYCLES=10, TRIP_LIMIT=3, WINDOW_CYCLES=100, DUTY_W=8.
- Soft start: reset, DUTY_REQ=5, DIR_REQ=0 -> DUTY_OUT steps 0,1,...,5, one step per 4 cycles, holds 5; DIR_OUT=0, BUSY=0.
- Reversal: from DUTY_OUT=5, set DIR_REQ=1 -> BUSY=1; duty ramps 5->0 over 20 cycles; 0 held 10 cycles with DIR_OUT=0; DIR_OUT becomes 1; duty ramps 0->5.
- Aborted reversal: DIR_REQ=1 while DUTY_OUT=5, back to 0 at DUTY_OUT=3 -> returns to RUN, ramps 3->5, DIR_OUT never changes.
- Trip window: 3 OVER1 pulses within 100 cycles -> FAULT=1 and DUTY_OUT=0 immediately; 2 pulses, then a 3rd after window expiry -> no fault, count=1.
- Fault clear: in FAULT, FAULT_CLR=1 with DUTY_REQ=5 -> stays FAULT; set DUTY_REQ=0 -> FAULT=0, RUN, DUTY_OUT=0.
- Async reset in DEAD: assert RST mid-count -> DUTY_OUT=0, DIR_OUT=0, BUSY=0 without waiting for a clock edge.
